adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
- Target-side model of the iceFUN ADC serial protocol: it plays the board's ADC in both simulation and loopback tests on a second board.
- Receives a one-byte channel request (0xA1..0xA4) on rx at 250 kbaud, 8N1.
- Snapshots the selected 10-bit channel value and replies on tx with two frames: low byte, then {6'b0, value[9:8]}.
- Sits on the rx/tx pins opposite the FPGA-side ADC poller.

Parameters:
- TICKS_PER_BIT, 48, clk12MHz cycles per serial bit (12 MHz / 250 kbaud); must be >= 4.
- CH_BASE, 8'hA1, request code of channel 0; channel n is CH_BASE+n.
- NUM_CH, 4, number of channels, 1..4.
- RESP_GAP_BITS, 1, idle bit-times between the request stop-bit sample and the reply start bit; 0 allowed.

Ports:
- clk12MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input from the poller; idle high; asynchronous to clk12MHz.
- tx  out  1  serial output to the poller; idle high.
- ch_values  in  40  packed channel values; channel n is [10n+9:10n].
- busy  out  1  high while a reply is pending or being sent.
- cmd_valid  out  1  one-cycle pulse when a request is accepted.
- cmd_chan  out  2  channel of the last accepted request; held until the next one.
- bad_cmd  out  1  one-cycle pulse when a well-framed byte is not a valid request code.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a valid request arrives while busy.

Behaviour:
- Reset values: tx=1, busy=0, cmd_valid=0, cmd_chan=0, bad_cmd=0, frame_err=0, overrun=0; rx synchronizer flops=1; both FSMs idle.
- Reset asserted mid-frame aborts the frame immediately; tx is forced high asynchronously.
- rx passes through a 2-flop synchronizer; all rx logic uses the synchronized value rxs.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: on rxs==0, load the tick counter with TICKS_PER_BIT/2 and go to R_START.
  - R_START: at counter expiry, if rxs==1 (glitch) return to R_IDLE silently; else reload TICKS_PER_BIT, bit index = 0, go to R_DATA.
  - R_DATA: sample at each expiry, LSB first; after 8 bits go to R_STOP.
  - R_STOP: sample at expiry (cycle T).
    - rxs==0: pulse frame_err, discard the byte, then wait in R_IDLE until rxs==1 before re-arming the start detector.
    - rxs==1 and byte in CH_BASE..CH_BASE+NUM_CH-1 with busy==0: at T+1 latch value = ch_values[chan], set cmd_chan, pulse cmd_valid, start the reply.
    - Valid code with busy==1: pulse overrun, no other effect; the reply in progress is unaffected.
    - Any other byte: pulse bad_cmd.
  - RX returns to R_IDLE at T+1 in all cases; it runs full-duplex while TX is busy.
- TX FSM states: T_IDLE, T_GAP, T_FRAME.
  - Accepting a request sets busy at T+1.
  - T_GAP lasts RESP_GAP_BITS*TICKS_PER_BIT cycles with tx=1; it is skipped when the parameter is 0.
  - The start bit of byte0 is driven starting at cycle T+2+RESP_GAP_BITS*TICKS_PER_BIT.
  - Each frame is 10 bits (start 0, data LSB first, stop 1), each exactly TICKS_PER_BIT cycles; shift register {1, data, 0}.
  - byte0 = value[7:0]; byte1 = {6'b0, value[9:8]} follows with no gap, its start bit immediately after byte0's stop bit.
  - busy drops in the cycle after byte1's stop bit completes; total reply = 20*TICKS_PER_BIT cycles after the gap.
- The value snapshot is held for the whole reply; later ch_values changes do not affect it.
- Internal bit counters are 4 bits; the tick counter is wide enough for TICKS_PER_BIT with no wrap ambiguity.

Test Plan:
- ch_values[9:0]=10'h2B7, send 0xA1 → cmd_valid pulse, cmd_chan=0; tx carries 0xB7 then 0x02; first tx fall exactly 1+48+1 cycles after the stop-bit sample; busy high for 49+960 cycles.
- ch_values[39:30]=10'h3FF, send 0xA4, change ch_values mid-reply → tx carries 0xFF then 0x03 (snapshot held).
- Send 0x55, then 0xA5 → two bad_cmd pulses, tx stays 1, busy stays 0.
- Send 0xA2 with stop bit forced 0 → frame_err pulse, no reply; rx held low for 3 bit-times, then a valid 0xA2 → normal reply.
- Send 0xA3 during an active reply, plus a 10-cycle rx low glitch while idle → overrun pulse with the first reply unchanged; the glitch produces no pulses and no reply.
- Assert reset during byte0's data bits → tx=1 and busy=0 with no clock edge; after release, 0xA1 gets a correct reply.

Source files
------------

// File: rtl/adc_responder_if.sv
// Pin-side bundle of the ADC responder: serial pair, channel values and status strobes.
`timescale 1ns/1ps
interface adc_responder_if;
  logic        rx;
  logic        tx;
  logic [39:0] ch_values;
  logic        busy;
  logic        cmd_valid;
  logic [1:0]  cmd_chan;
  logic        bad_cmd;
  logic        frame_err;
  logic        overrun;

  modport slave (
    input  rx, ch_values,
    output tx, busy, cmd_valid, cmd_chan, bad_cmd, frame_err, overrun
  );

  modport master (
    output rx, ch_values,
    input  tx, busy, cmd_valid, cmd_chan, bad_cmd, frame_err, overrun
  );
endinterface

// File: rtl/adc_responder.sv
// Target-side model of the iceFUN ADC serial protocol: takes a one-byte channel
// request on rx and answers on tx with the snapshotted 10-bit value as two 8N1 frames.
`timescale 1ns/1ps
module adc_responder #(
  parameter int unsigned TICKS_PER_BIT = 48,
  parameter logic [7:0]  CH_BASE       = 8'hA1,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned RESP_GAP_BITS = 1
) (
  input logic          clk12MHz,
  input logic          reset,
  adc_responder_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(TICKS_PER_BIT + 1);
  localparam int unsigned GAP_TICKS = RESP_GAP_BITS * TICKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_TICKS + 2);
  localparam logic [CNT_W-1:0] BIT_TICKS  = CNT_W'(TICKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TICKS = CNT_W'(TICKS_PER_BIT / 2);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_GAP, T_FRAME} tx_state_e;

  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_wait_q, rx_wait_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [9:0]       tx_sh_q, tx_sh_d;
  logic             tx_byte1_q, tx_byte1_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [9:0]       value_q, value_d;

  logic [1:0]       cmd_chan_q, cmd_chan_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             bad_cmd_q, bad_cmd_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [8:0]       code_off_c;
  logic             code_ok_c;
  logic [1:0]       chan_c;
  logic [9:0]       sel_val_c;
  logic             rx_tick_c;
  logic             load_byte_c;
  logic             load_hi_c;

  // Request decode: codes below CH_BASE wrap into bit 8 and fail the range test.
  always_comb begin
    code_off_c = {1'b0, rx_sh_q} - {1'b0, CH_BASE};
    code_ok_c  = (code_off_c < 9'(NUM_CH));
    chan_c     = code_off_c[1:0];
    case (chan_c)
      2'd0:    sel_val_c = bus.ch_values[9:0];
      2'd1:    sel_val_c = bus.ch_values[19:10];
      2'd2:    sel_val_c = bus.ch_values[29:20];
      default: sel_val_c = bus.ch_values[39:30];
    endcase
  end

  always_comb begin
    rx_meta_d   = bus.rx;
    rxs_d       = rx_meta_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_wait_d   = rx_wait_q;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_byte1_d  = tx_byte1_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    value_d     = value_q;
    cmd_chan_d  = cmd_chan_q;
    cmd_valid_d = 1'b0;
    bad_cmd_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load_byte_c = 1'b0;
    load_hi_c   = 1'b0;
    rx_tick_c   = (rx_cnt_q == CNT_W'(1));

    // Receiver: mid-bit sampling from the synchronized line.
    case (rx_state_q)
      R_IDLE: begin
        if (rx_wait_q) begin
          if (rxs_q) rx_wait_d = 1'b0;
        end else if (!rxs_q) begin
          rx_cnt_d   = HALF_TICKS;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_tick_c) begin
          if (rxs_q) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_cnt_d   = BIT_TICKS;
            rx_bit_d   = 4'd0;
            rx_state_d = R_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_tick_c) begin
          rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_TICKS;
          if (rx_bit_q == 4'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      R_STOP: begin
        if (rx_tick_c) begin
          rx_state_d = R_IDLE;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            rx_wait_d   = 1'b1;
          end else if (code_ok_c) begin
            if (busy_q) begin
              overrun_d = 1'b1;
            end else begin
              cmd_valid_d = 1'b1;
              cmd_chan_d  = chan_c;
              value_d     = sel_val_c;
              busy_d      = 1'b1;
            end
          end else begin
            bad_cmd_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase

    // Transmitter: kicked off by the registered accept strobe.
    case (tx_state_q)
      T_IDLE: begin
        if (cmd_valid_q) begin
          if (GAP_TICKS == 0) begin
            load_byte_c = 1'b1;
          end else begin
            gap_cnt_d  = GAP_W'(GAP_TICKS);
            tx_state_d = T_GAP;
          end
        end
      end
      T_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) load_byte_c = 1'b1;
        else                        gap_cnt_d   = gap_cnt_q - GAP_W'(1);
      end
      T_FRAME: begin
        if (tx_cnt_q == CNT_W'(1)) begin
          if (tx_bit_q == 4'd9) begin
            if (!tx_byte1_q) begin
              load_byte_c = 1'b1;
              load_hi_c   = 1'b1;
            end else begin
              tx_state_d = T_IDLE;
              tx_d       = 1'b1;
              busy_d     = 1'b0;
            end
          end else begin
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_d     = tx_sh_q[1];
            tx_bit_d = tx_bit_q + 4'd1;
            tx_cnt_d = BIT_TICKS;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    // Frame load puts the start bit on the line in the same step.
    if (load_byte_c) begin
      tx_sh_d    = {1'b1, (load_hi_c ? {6'b0, value_q[9:8]} : value_q[7:0]), 1'b0};
      tx_d       = 1'b0;
      tx_cnt_d   = BIT_TICKS;
      tx_bit_d   = 4'd0;
      tx_byte1_d = load_hi_c;
      tx_state_d = T_FRAME;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_wait_q   <= 1'b0;
      tx_state_q  <= T_IDLE;
      tx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '1;
      tx_byte1_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      value_q     <= '0;
      cmd_chan_q  <= '0;
      cmd_valid_q <= 1'b0;
      bad_cmd_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_wait_q   <= rx_wait_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_byte1_q  <= tx_byte1_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      value_q     <= value_d;
      cmd_chan_q  <= cmd_chan_d;
      cmd_valid_q <= cmd_valid_d;
      bad_cmd_q   <= bad_cmd_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_chan  = cmd_chan_q;
  assign bus.bad_cmd   = bad_cmd_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: vector table of requests plus hand-built corner sequences,
// with a UART decoder on tx feeding a byte scoreboard.
`timescale 1ns/1ps
module tb_adc_responder;
  localparam int unsigned TPB = 48;
  localparam int GAP_LAT  = 1 * TPB + 1;
  localparam int BUSY_LEN = 1 + 1 * TPB + 20 * TPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_responder_if bus();

  adc_responder #(
    .TICKS_PER_BIT(TPB), .CH_BASE(8'hA1), .NUM_CH(4), .RESP_GAP_BITS(1)
  ) dut (
    .clk12MHz(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Event monitor: pulse counts, accept time, first tx fall after accept, busy run length.
  int cyc = 0, cv_n = 0, bad_n = 0, fe_n = 0, ov_n = 0;
  int cv_cyc = 0, fall_cyc = 0, busy_run = 0, busy_len = 0;
  logic tx_prev = 1'b1;
  logic fall_seen = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (bus.cmd_valid === 1'b1) begin cv_n++; cv_cyc = cyc; fall_seen = 1'b0; end
    if (bus.bad_cmd === 1'b1)   bad_n++;
    if (bus.frame_err === 1'b1) fe_n++;
    if (bus.overrun === 1'b1)   ov_n++;
    if (!fall_seen && tx_prev && !bus.tx) begin fall_cyc = cyc; fall_seen = 1'b1; end
    if (bus.busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin busy_len = busy_run; busy_run = 0; end
    tx_prev = bus.tx;
  end

  // UART decoder on tx; aborts on reset.
  logic [7:0] got_mem [0:63];
  logic       got_stop [0:63];
  int   got_wr = 0;
  int   d_cnt = 0, d_ph = 0;
  logic d_act = 1'b0, d_prev = 1'b1;
  logic [7:0] d_sh = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      d_act  = 1'b0;
      d_prev = 1'b1;
    end else begin
      if (!d_act) begin
        if (d_prev && !bus.tx) begin d_act = 1'b1; d_cnt = TPB / 2 - 1; d_ph = 0; end
      end else if (d_cnt != 0) begin
        d_cnt--;
      end else begin
        d_cnt = TPB - 1;
        if (d_ph >= 1 && d_ph <= 8) d_sh = {bus.tx, d_sh[7:1]};
        if (d_ph == 9) begin
          got_mem[got_wr % 64]  = d_sh;
          got_stop[got_wr % 64] = bus.tx;
          got_wr++;
          d_act = 1'b0;
        end
        d_ph++;
      end
      d_prev = bus.tx;
    end
  end

  logic [9:0] chv [4];
  logic [7:0] exp_q [$];
  int rd_idx = 0;

  function automatic logic [39:0] pack_ch();
    return {chv[3], chv[2], chv[1], chv[0]};
  endfunction

  task automatic push_reply(input logic [9:0] v);
    exp_q.push_back(v[7:0]);
    exp_q.push_back({6'b0, v[9:8]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int hold_bits);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      repeat (TPB) @(posedge clk);
      #1;
    end
    if (hold_bits > 0) begin
      repeat (hold_bits * TPB) @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
  endtask

  task automatic wait_not_busy(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    chk({name, " busy_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_tx_low(input string name, input int budget);
    int n;
    n = 0;
    while (bus.tx && n < budget) begin @(negedge clk); n++; end
    chk({name, " tx_start_timeout"}, 32'(bus.tx), 32'd0);
  endtask

  task automatic check_bytes(input string name);
    logic [7:0] e;
    chk({name, " byte_count"}, 32'(got_wr - rd_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_idx < got_wr) begin
      e = exp_q.pop_front();
      chk({name, " byte"}, 32'(got_mem[rd_idx % 64]), 32'(e));
      chk({name, " stop"}, 32'(got_stop[rd_idx % 64]), 32'd1);
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = got_wr;
  endtask

  typedef struct {
    logic [7:0] code;
    logic       exp_valid;
    logic       exp_bad;
    logic [1:0] exp_chan;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cv0, bad0, fe0, ov0;
    bus.rx = 1'b1;
    chv[0] = 10'h2B7; chv[1] = 10'h155; chv[2] = 10'h0AA; chv[3] = 10'h3FF;
    bus.ch_values = pack_ch();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst tx",        32'(bus.tx),        32'd1);
    chk("rst busy",      32'(bus.busy),      32'd0);
    chk("rst cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst cmd_chan",  32'(bus.cmd_chan),  32'd0);
    chk("rst bad_cmd",   32'(bus.bad_cmd),   32'd0);
    chk("rst frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst overrun",   32'(bus.overrun),   32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    vecs[0] = '{8'hA1, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{8'hA2, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{8'hA3, 1'b1, 1'b0, 2'd2};
    vecs[3] = '{8'hA4, 1'b1, 1'b0, 2'd3};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 2'd0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 2'd0};
    vecs[6] = '{8'hA0, 1'b0, 1'b1, 2'd0};

    for (int i = 0; i < 7; i++) begin
      cv0 = cv_n; bad0 = bad_n; fe0 = fe_n;
      @(posedge clk); #1;
      if (vecs[i].exp_valid) push_reply(chv[vecs[i].exp_chan]);
      send_byte(vecs[i].code, 1'b1, 0);
      repeat (TPB) @(negedge clk);
      chk($sformatf("vec%0d cmd_valid", i), 32'(cv_n - cv0),  32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d bad_cmd", i),   32'(bad_n - bad0), 32'(vecs[i].exp_bad));
      chk($sformatf("vec%0d frame_err", i), 32'(fe_n - fe0),   32'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d cmd_chan", i), 32'(bus.cmd_chan), 32'(vecs[i].exp_chan));
        wait_not_busy($sformatf("vec%0d", i), 1500);
        chk($sformatf("vec%0d first_fall_latency", i), 32'(fall_cyc - cv_cyc), 32'(GAP_LAT));
        chk($sformatf("vec%0d busy_len", i), 32'(busy_len), 32'(BUSY_LEN));
      end else begin
        chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'd0);
        chk($sformatf("vec%0d tx", i),   32'(bus.tx),   32'd1);
      end
      check_bytes($sformatf("vec%0d", i));
    end

    // Snapshot held while ch_values changes mid-reply.
    @(posedge clk); #1;
    push_reply(chv[3]);
    send_byte(8'hA4, 1'b1, 0);
    wait_tx_low("snap", 200);
    repeat (3 * TPB) @(negedge clk);
    chv[3] = 10'h000; chv[2] = 10'h123;
    bus.ch_values = pack_ch();
    wait_not_busy("snap", 1500);
    check_bytes("snap");

    // Framing error, line held low, then a clean request.
    cv0 = cv_n; bad0 = bad_n; fe0 = fe_n;
    @(posedge clk); #1;
    send_byte(8'hA2, 1'b0, 3);
    repeat (2 * TPB) @(negedge clk);
    chk("ferr frame_err", 32'(fe_n - fe0),   32'd1);
    chk("ferr cmd_valid", 32'(cv_n - cv0),   32'd0);
    chk("ferr bad_cmd",   32'(bad_n - bad0), 32'd0);
    chk("ferr busy",      32'(bus.busy),     32'd0);
    check_bytes("ferr");
    cv0 = cv_n;
    @(posedge clk); #1;
    push_reply(chv[1]);
    send_byte(8'hA2, 1'b1, 0);
    repeat (TPB) @(negedge clk);
    chk("ferr_recover cmd_valid", 32'(cv_n - cv0), 32'd1);
    chk("ferr_recover cmd_chan",  32'(bus.cmd_chan), 32'd1);
    wait_not_busy("ferr_recover", 1500);
    check_bytes("ferr_recover");

    // Overrun during a reply.
    cv0 = cv_n; ov0 = ov_n;
    @(posedge clk); #1;
    push_reply(chv[0]);
    send_byte(8'hA1, 1'b1, 0);
    send_byte(8'hA3, 1'b1, 0);
    repeat (TPB) @(negedge clk);
    chk("ovr overrun",   32'(ov_n - ov0), 32'd1);
    chk("ovr cmd_valid", 32'(cv_n - cv0), 32'd1);
    chk("ovr cmd_chan",  32'(bus.cmd_chan), 32'd0);
    wait_not_busy("ovr", 1500);
    chk("ovr busy_len", 32'(busy_len), 32'(BUSY_LEN));
    check_bytes("ovr");

    // Short low glitch while idle.
    cv0 = cv_n; bad0 = bad_n; fe0 = fe_n; ov0 = ov_n;
    @(posedge clk); #1;
    bus.rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (3 * TPB) @(negedge clk);
    chk("glitch pulses", 32'((cv_n - cv0) + (bad_n - bad0) + (fe_n - fe0) + (ov_n - ov0)), 32'd0);
    chk("glitch busy", 32'(bus.busy), 32'd0);
    check_bytes("glitch");

    // Reset during byte0 data bits (bit 3 of 0xB7 is low).
    @(posedge clk); #1;
    send_byte(8'hA1, 1'b1, 0);
    wait_tx_low("rstmid", 200);
    repeat (4 * TPB + 10) @(negedge clk);
    chk("rstmid pre tx", 32'(bus.tx), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rstmid tx",   32'(bus.tx),   32'd1);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rd_idx = got_wr;
    repeat (5) @(negedge clk);
    cv0 = cv_n;
    @(posedge clk); #1;
    push_reply(chv[0]);
    send_byte(8'hA1, 1'b1, 0);
    repeat (TPB) @(negedge clk);
    chk("rstmid cmd_valid", 32'(cv_n - cv0), 32'd1);
    wait_not_busy("rstmid", 1500);
    check_bytes("rstmid");

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
